mole_hit_scorer: RTL and testbench
==================================

# mole_hit_scorer

Downstream consumer of the per-button one-shot press pulses in the WhackMole datapath. Compares each single-cycle press against the current mole mask from the mole controller and classifies it as a hit or a miss. Maintains a saturating two-digit BCD score and a hit streak. Returns per-hole whack pulses so the mole controller can retract struck moles.

## Interface
Parameters:
- `HOLES`, default 8, number of holes/buttons (1..8).

Ports:
- `clk`  input  1  system clock; all logic on rising edge.
- `rst_n`  input  1  reset, synchronous, active-low.
- `start_i`  input  1  single-cycle pulse; clears score/streak and enters PLAY.
- `stop_i`  input  1  single-cycle pulse; ends the round (PLAY -> DONE).
- `press_i`  input  HOLES  one-shot press pulses, one bit per hole (from edge-detect stage).
- `mole_i`  input  HOLES  level mask of moles currently up.
- `whack_o`  output  HOLES  one-cycle pulse per hole struck this cycle.
- `hit_o`  output  1  one-cycle pulse: at least one hit this cycle.
- `miss_o`  output  1  one-cycle pulse: at least one miss this cycle.
- `score_bcd_o`  output  8  score, {tens, ones} BCD, range 00..99.
- `streak_o`  output  4  consecutive hits since last miss, saturating at 15.
- `playing_o`  output  1  high in PLAY.
- `done_o`  output  1  high in DONE.

## Operation
- States: IDLE (after reset), PLAY, DONE.
  - IDLE -> PLAY on `start_i`.
  - PLAY -> DONE on `stop_i`.
  - DONE -> PLAY on `start_i`.
  - No other transitions.
- `start_i` in any state clears score, streak and all hit-lock flags. Presses in that same cycle are ignored.
- `start_i` and `stop_i` asserted together: start wins (-> PLAY, cleared).
- Hit-lock flag per hole:
  - Set when that hole is whacked.
  - Cleared whenever `mole_i[k]`=0.
  - A locked hole is masked out of hit/miss evaluation.
- Per cycle in PLAY, with `eff` = `press_i` & ~lock:
  - hits = `eff` & `mole_i`; misses = `eff` & ~`mole_i`.
  - `whack_o` = hits; `hit_o` = |hits; `miss_o` = |misses.
  - Score: new = min(99, score + popcount(hits)) (penalty variant under Configuration).
  - Streak: any miss -> 0. Else streak = min(15, streak + popcount(hits)).
- A press on a locked hole produces no whack, hit, miss, score or streak change.
- Presses in the cycle `stop_i` is sampled are still scored. The DONE state is entered at the same edge.
- IDLE and DONE:
  - `press_i` ignored.
  - `whack_o`, `hit_o`, `miss_o` held 0.
  - Score and streak hold.
- Score is kept as two BCD digits. Carry from ones to tens digit is resolved within the single update cycle. No digit ever exceeds 9.

## Timing
- Reset values (at the first edge with `rst_n`=0):
  - State IDLE; `whack_o`=0, `hit_o`=0, `miss_o`=0.
  - `score_bcd_o`=8'h00, `streak_o`=0, `playing_o`=0, `done_o`=0.
  - Lock flags cleared.
- Reset asserted mid-round aborts immediately at that edge. No partial update.
- Latency: press sampled at edge n. Then `whack_o`, `hit_o`, `miss_o`, `score_bcd_o` and `streak_o` are all valid after edge n, as registered outputs, with 1-cycle latency.
- `whack_o`, `hit_o` and `miss_o` are high for exactly one cycle per event.
- `playing_o` and `done_o` change at the same edge as the state.
- Lock flag set at edge n affects evaluation from cycle n+1 onward.
- Hit and miss in the same cycle on different holes: both pulses fire. Score adds hits; streak goes to 0.

## Configuration
- Macro `WHACKMOLE_MISS_PENALTY_EN`.
- Defined: score update becomes new = clamp(score + popcount(hits) − popcount(misses), 0, 99), computed in one step (no intermediate clamp). Example: score 00 with 1 hit and 2 misses gives 00.
- Undefined: misses never change the score. Only `miss_o` and the streak reset react to a miss.

## Test plan
- Reset, then `start_i`; press hole 2 with `mole_i`=8'h04 -> next cycle `whack_o`=8'h04, `hit_o`=1, score 8'h01, streak 1.
- Mole 2 held up; press hole 2 again twice -> no whack, hit or miss, score stays 01. Drop `mole_i`, raise it again, press -> score 02.
- Preload to 97 via hits; one cycle with presses on 4 up-moles -> score 8'h99, streak 15 if reached, no digit > 9. Also check 09 + 1 -> 8'h10.
- With 3 hits accrued, press a hole with no mole -> `miss_o`=1, streak 0. Score unchanged (macro undefined) or decremented by 1 (macro defined). Score 00 plus a miss stays 00.
- Presses while in IDLE and while in DONE -> no pulses, score frozen. `start_i` and `stop_i` in the same cycle -> PLAY, score 00.
- Assert `rst_n`=0 for one cycle mid-round with a press pending -> all outputs at reset values, state IDLE, press not scored.

Source files
------------

// File: rtl/mole_hit_scorer.sv
// Classifies one-shot button presses against the mole mask, keeps a saturating BCD score and
// a hit streak. Define WHACKMOLE_MISS_PENALTY_EN to make misses subtract from the score.
module mole_hit_scorer #(
    parameter int unsigned HOLES = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic [HOLES-1:0] press_i,
    input  logic [HOLES-1:0] mole_i,
    output logic [HOLES-1:0] whack_o,
    output logic             hit_o,
    output logic             miss_o,
    output logic [7:0]       score_bcd_o,
    output logic [3:0]       streak_o,
    output logic             playing_o,
    output logic             done_o
);

    typedef enum logic [1:0] {
        StIdle,
        StPlay,
        StDone
    } state_e;

    state_e           r_state;
    state_e           w_state_next;
    logic [HOLES-1:0] r_lock;
    logic [HOLES-1:0] w_lock_next;
    logic [HOLES-1:0] r_whack;
    logic             r_hit;
    logic             r_miss;
    logic [7:0]       r_score;
    logic [7:0]       w_score_next;
    logic [3:0]       r_streak;
    logic [3:0]       w_streak_next;

    logic             w_play_eval;
    logic [HOLES-1:0] w_lock_eff;
    logic [HOLES-1:0] w_eff;
    logic [HOLES-1:0] w_hits;
    logic [HOLES-1:0] w_misses;
    logic [3:0]       w_hit_cnt;
    logic [6:0]       w_score_bin;
    logic signed [8:0] w_sum;
    logic [6:0]       w_score_clamped;
    logic [4:0]       w_streak_sum;
`ifdef WHACKMOLE_MISS_PENALTY_EN
    logic [3:0]       w_miss_cnt;
`endif

    function automatic logic [3:0] popcount(input logic [HOLES-1:0] v);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < HOLES; i++) begin
            c = c + {3'b000, v[i]};
        end
        return c;
    endfunction

    // Repeated subtraction; input is already clamped to 0..99 so nine passes suffice.
    function automatic logic [7:0] to_bcd(input logic [6:0] v);
        logic [3:0] t;
        logic [6:0] r;
        t = 4'd0;
        r = v;
        for (int i = 0; i < 9; i++) begin
            if (r >= 7'd10) begin
                r = r - 7'd10;
                t = t + 4'd1;
            end
        end
        return {t, 4'(r)};
    endfunction

    // Evaluation masks: a lock only counts while its mole is still up.
    always_comb begin
        w_play_eval = (r_state == StPlay) && !start_i;
        w_lock_eff  = r_lock & mole_i;
        w_eff       = press_i & ~w_lock_eff;
        w_hits      = w_play_eval ? (w_eff & mole_i) : '0;
        w_misses    = w_play_eval ? (w_eff & ~mole_i) : '0;
        w_hit_cnt   = popcount(w_hits);
`ifdef WHACKMOLE_MISS_PENALTY_EN
        w_miss_cnt  = popcount(w_misses);
`endif
        w_lock_next = start_i ? '0 : ((r_lock | w_hits) & mole_i);
    end

    // Score arithmetic is done in binary with a single clamp, then re-encoded to BCD.
    always_comb begin
        w_score_bin = ({3'b000, r_score[7:4]} * 7'd10) + {3'b000, r_score[3:0]};
        w_sum       = $signed({2'b00, w_score_bin}) + $signed({5'b00000, w_hit_cnt});
`ifdef WHACKMOLE_MISS_PENALTY_EN
        w_sum       = w_sum - $signed({5'b00000, w_miss_cnt});
`endif
        if (w_sum < 9'sd0) begin
            w_score_clamped = 7'd0;
        end else if (w_sum > 9'sd99) begin
            w_score_clamped = 7'd99;
        end else begin
            w_score_clamped = 7'(w_sum);
        end

        w_streak_sum = {1'b0, r_streak} + {1'b0, w_hit_cnt};

        w_score_next  = r_score;
        w_streak_next = r_streak;
        if (start_i) begin
            w_score_next  = 8'h00;
            w_streak_next = 4'd0;
        end else if (w_play_eval) begin
            w_score_next = to_bcd(w_score_clamped);
            if (|w_misses) begin
                w_streak_next = 4'd0;
            end else if (w_streak_sum > 5'd15) begin
                w_streak_next = 4'd15;
            end else begin
                w_streak_next = 4'(w_streak_sum);
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: if (start_i) w_state_next = StPlay;
            StPlay: if (start_i) w_state_next = StPlay;
                    else if (stop_i) w_state_next = StDone;
            StDone: if (start_i) w_state_next = StPlay;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= StIdle;
            r_lock   <= '0;
            r_whack  <= '0;
            r_hit    <= 1'b0;
            r_miss   <= 1'b0;
            r_score  <= 8'h00;
            r_streak <= 4'd0;
        end else begin
            r_state  <= w_state_next;
            r_lock   <= w_lock_next;
            r_whack  <= w_hits;
            r_hit    <= |w_hits;
            r_miss   <= |w_misses;
            r_score  <= w_score_next;
            r_streak <= w_streak_next;
        end
    end

    assign whack_o     = r_whack;
    assign hit_o       = r_hit;
    assign miss_o      = r_miss;
    assign score_bcd_o = r_score;
    assign streak_o    = r_streak;
    assign playing_o   = (r_state == StPlay);
    assign done_o      = (r_state == StDone);

endmodule

// File: tb/tb_mole_hit_scorer.sv
// Table-driven bench for mole_hit_scorer; expected scores follow WHACKMOLE_MISS_PENALTY_EN.
module tb_mole_hit_scorer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_i;
    logic       stop_i;
    logic [7:0] press_i;
    logic [7:0] mole_i;
    logic [7:0] whack_o;
    logic       hit_o;
    logic       miss_o;
    logic [7:0] score_bcd_o;
    logic [3:0] streak_o;
    logic       playing_o;
    logic       done_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      name;
        logic       rst_n;
        logic       start;
        logic       stop;
        logic [7:0] press;
        logic [7:0] mole;
        logic [7:0] whack;
        logic       hit;
        logic       miss;
        logic [7:0] score;
        logic [3:0] streak;
        logic       play;
        logic       done;
    } vec_t;

    vec_t vq[$];

    mole_hit_scorer #(.HOLES(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start_i),
        .stop_i     (stop_i),
        .press_i    (press_i),
        .mole_i     (mole_i),
        .whack_o    (whack_o),
        .hit_o      (hit_o),
        .miss_o     (miss_o),
        .score_bcd_o(score_bcd_o),
        .streak_o   (streak_o),
        .playing_o  (playing_o),
        .done_o     (done_o)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] bcd(input int v);
        logic [7:0] r;
        r[7:4] = 4'(v / 10);
        r[3:0] = 4'(v % 10);
        return r;
    endfunction

    task automatic chk(input string nm, input string f, input logic [7:0] got,
                       input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s.%s got %h expected %h", nm, f, got, exp);
        end
    endtask

    task automatic add(input string nm, input logic rn, input logic st, input logic sp,
                       input logic [7:0] pr, input logic [7:0] mo, input logic [7:0] wh,
                       input logic h, input logic m, input logic [7:0] sc, input logic [3:0] sk,
                       input logic pl, input logic dn);
        vec_t v;
        v.name = nm; v.rst_n = rn; v.start = st; v.stop = sp; v.press = pr; v.mole = mo;
        v.whack = wh; v.hit = h; v.miss = m; v.score = sc; v.streak = sk; v.play = pl;
        v.done = dn;
        vq.push_back(v);
    endtask

    task automatic drive(input logic rn, input logic st, input logic sp, input logic [7:0] pr,
                         input logic [7:0] mo);
        rst_n = rn; start_i = st; stop_i = sp; press_i = pr; mole_i = mo;
        @(posedge clk);
        #1;
    endtask

    task automatic run_vectors();
        foreach (vq[i]) begin
            drive(vq[i].rst_n, vq[i].start, vq[i].stop, vq[i].press, vq[i].mole);
            chk(vq[i].name, "whack", whack_o, vq[i].whack);
            chk(vq[i].name, "hit", {7'b0, hit_o}, {7'b0, vq[i].hit});
            chk(vq[i].name, "miss", {7'b0, miss_o}, {7'b0, vq[i].miss});
            chk(vq[i].name, "score", score_bcd_o, vq[i].score);
            chk(vq[i].name, "streak", {4'b0, streak_o}, {4'b0, vq[i].streak});
            chk(vq[i].name, "playing", {7'b0, playing_o}, {7'b0, vq[i].play});
            chk(vq[i].name, "done", {7'b0, done_o}, {7'b0, vq[i].done});
        end
        vq.delete();
    endtask

    initial begin
        logic [7:0] pen;
        int         exp_score;
        int         exp_streak;
`ifdef WHACKMOLE_MISS_PENALTY_EN
        pen = 8'h01;
`else
        pen = 8'h00;
`endif
        rst_n = 1'b0; start_i = 1'b0; stop_i = 1'b0; press_i = '0; mole_i = '0;

        //   name          rn st sp press  mole   whack  h  m  score          strk pl dn
        add("reset",       0, 0, 0, 8'hFF, 8'hFF, 8'h00, 0, 0, 8'h00,         0,  0, 0);
        add("idle_press",  1, 0, 0, 8'hFF, 8'hFF, 8'h00, 0, 0, 8'h00,         0,  0, 0);
        add("start",       1, 1, 0, 8'h04, 8'h04, 8'h00, 0, 0, 8'h00,         0,  1, 0);
        add("hit2",        1, 0, 0, 8'h04, 8'h04, 8'h04, 1, 0, 8'h01,         1,  1, 0);
        add("lock_a",      1, 0, 0, 8'h04, 8'h04, 8'h00, 0, 0, 8'h01,         1,  1, 0);
        add("lock_b",      1, 0, 0, 8'h04, 8'h04, 8'h00, 0, 0, 8'h01,         1,  1, 0);
        add("drop",        1, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 8'h01,         1,  1, 0);
        add("rehit",       1, 0, 0, 8'h04, 8'h04, 8'h04, 1, 0, 8'h02,         2,  1, 0);
        add("hit0",        1, 0, 0, 8'h01, 8'h01, 8'h01, 1, 0, 8'h03,         3,  1, 0);
        add("miss",        1, 0, 0, 8'h80, 8'h01, 8'h00, 0, 1, 8'h03 - pen,   0,  1, 0);
        add("lock_mix",    1, 0, 0, 8'h03, 8'h03, 8'h02, 1, 0, 8'h04 - pen,   1,  1, 0);
        add("clear",       1, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 8'h04 - pen,   1,  1, 0);
        add("restart",     1, 1, 0, 8'h00, 8'h00, 8'h00, 0, 0, 8'h00,         0,  1, 0);
        add("four_lo",     1, 0, 0, 8'h0F, 8'hFF, 8'h0F, 1, 0, 8'h04,         4,  1, 0);
        add("four_hi",     1, 0, 0, 8'hF0, 8'hFF, 8'hF0, 1, 0, 8'h08,         8,  1, 0);
        add("clear2",      1, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 8'h08,         8,  1, 0);
        add("to_09",       1, 0, 0, 8'h01, 8'h01, 8'h01, 1, 0, 8'h09,         9,  1, 0);
        add("carry",       1, 0, 0, 8'h02, 8'h02, 8'h02, 1, 0, 8'h10,         10, 1, 0);
        add("miss8",       1, 0, 0, 8'hFF, 8'h00, 8'h00, 0, 1,
            (pen != 0) ? 8'h02 : 8'h10, 0, 1, 0);
        add("hit_and_miss", 1, 0, 0, 8'h81, 8'h80, 8'h80, 1, 1,
            (pen != 0) ? 8'h02 : 8'h11, 0, 1, 0);
        add("restart2",    1, 1, 0, 8'h00, 8'h00, 8'h00, 0, 0, 8'h00,         0,  1, 0);
        add("floor",       1, 0, 0, 8'h01, 8'h00, 8'h00, 0, 1, 8'h00,         0,  1, 0);
        add("quiet",       1, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 8'h00,         0,  1, 0);
        run_vectors();

        // Ramp to 97 with alternating full-board hits and mole drops.
        exp_score = 0;
        exp_streak = 0;
        for (int i = 1; i <= 12; i++) begin
            drive(1'b1, 1'b0, 1'b0, 8'hFF, 8'hFF);
            exp_score += 8;
            exp_streak = (exp_streak + 8 > 15) ? 15 : exp_streak + 8;
            chk("ramp", "whack", whack_o, 8'hFF);
            chk("ramp", "score", score_bcd_o, bcd(exp_score));
            chk("ramp", "streak", {4'b0, streak_o}, 8'(exp_streak));
            drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        end
        drive(1'b1, 1'b0, 1'b0, 8'h01, 8'h01);
        chk("to_97", "score", score_bcd_o, 8'h97);
        drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);

        //   name          rn st sp press  mole   whack  h  m  score          strk pl dn
        add("sat99",       1, 0, 0, 8'h0F, 8'h0F, 8'h0F, 1, 0, 8'h99,         15, 1, 0);
        add("stop_scored", 1, 0, 1, 8'h10, 8'h00, 8'h00, 0, 1, 8'h99 - pen,   0,  0, 1);
        add("done_press",  1, 0, 0, 8'hFF, 8'hFF, 8'h00, 0, 0, 8'h99 - pen,   0,  0, 1);
        add("start_stop",  1, 1, 1, 8'hFF, 8'hFF, 8'h00, 0, 0, 8'h00,         0,  1, 0);
        add("hit1",        1, 0, 0, 8'h02, 8'h02, 8'h02, 1, 0, 8'h01,         1,  1, 0);
        add("reset_mid",   0, 0, 0, 8'h04, 8'h04, 8'h00, 0, 0, 8'h00,         0,  0, 0);
        add("after_reset", 1, 0, 0, 8'h04, 8'h04, 8'h00, 0, 0, 8'h00,         0,  0, 0);
        run_vectors();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
